// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
//   state_t      : controller FSM state (2-bit encoding)
//   DefaultWidth : default operand/sum width in bits
package serial_add_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_add  = 2'd1,
        st_done = 2'd2
    } state_t;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
// Ports:
//   a, b  in  : operand bits
//   cin   in  : carry in
//   sum   out : a ^ b ^ cin
//   cout  out : majority(a, b, cin)
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition controller: sequences one adder_1bit cell over WIDTH-bit
// operands, LSB first, carrying between steps in a flop. start/busy/done handshake.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : request, sampled only in idle
//   a, b, cin      : operands and carry in, captured on the accepted start edge
//   busy           : high while bits are being added
//   done           : one-cycle pulse, result valid
//   sum, cout      : result; held until the next accepted start or reset
//   ovf            : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic            c;
    logic [CntW-1:0] cnt;
    logic            cell_sum;
    logic            cell_cout;
    logic            last_bit;

    adder_1bit u_cell (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    assign last_bit = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            st_idle: begin
                if (start) state_next = st_add;
            end
            st_add: begin
                busy = 1'b1;
                if (last_bit) state_next = st_done;
            end
            st_done: begin
                done       = 1'b1;
                state_next = st_idle;
            end
            default: state_next = st_idle;
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Carry into the MSB, captured on the final bit step.
    logic c_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_msb <= 1'b0;
        end else if (state == st_idle && start) begin
            c_msb <= 1'b0;
        end else if (state == st_add && last_bit) begin
            c_msb <= c;
        end
    end

    assign ovf = c_msb ^ cout;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        c    <= cin;
                        cnt  <= CntW'(WIDTH - 1);
                        sum  <= '0;
                        cout <= 1'b0;
                    end
                end
                st_add: begin
                    // Result bits enter at the MSB so bit 0 ends up holding the first sum bit.
                    sum <= {cell_sum, sum[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= cell_cout;
                    cnt <= cnt - CntW'(1);
                    if (last_bit) cout <= cell_cout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8): directed cases plus
// random operands compared against plain word-level arithmetic.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int done_seen = 0;
    int overlap   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
        if (done && busy) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Runs one addition. ignore_at: cycle index k at whose closing edge E(k) a spurious
    // start is presented (0 = none). rst_at: edge E(k) at which reset is applied (0 = none).
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input int ignore_at, input int rst_at);
        logic [W:0] exp_full;
        logic       exp_ovf;
        int         bad_busy;
        int         done0;
        exp_full = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        exp_ovf  = (oa[W-1] == ob[W-1]) && (exp_full[W-1] != oa[W-1]);
        bad_busy = 0;
        @(negedge clk);
        a = oa; b = ob; cin = oc; start = 1'b1;
        @(posedge clk);
        done0 = done_seen;
        for (int k = 1; k <= int'(W) + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            if (k == int'(W) + 1) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("busy_in_done", {31'd0, busy}, 32'd0);
                check("sum", {24'd0, sum}, {24'd0, exp_full[W-1:0]});
                check("cout", {31'd0, cout}, {31'd0, exp_full[W]});
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", {31'd0, ovf}, {31'd0, exp_ovf});
`endif
            end else begin
                if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
            end
            if (ignore_at == k) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end
            if (rst_at == k) begin
                rst = 1'b1;
                break;
            end
        end
        if (rst_at != 0) begin
            @(negedge clk);
            rst = 1'b0;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_sum", {24'd0, sum}, 32'd0);
            check("abort_cout", {31'd0, cout}, 32'd0);
            repeat (W + 2) @(negedge clk);
            check("abort_no_done", done_seen - done0, 32'd0);
        end else begin
            check("busy_window", bad_busy, 32'd0);
            @(negedge clk);
            check("done_fall", {31'd0, done}, 32'd0);
            check("sum_hold", {24'd0, sum}, {24'd0, exp_full[W-1:0]});
            check("done_count", done_seen - done0, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
        // Reset wins over a same-cycle start.
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(negedge clk);
        check("rst_vs_start", {31'd0, busy}, 32'd0);
        rst = 1'b0; start = 1'b0;

        run_op(8'h35, 8'h1C, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 0);
        run_op(8'h10, 8'h20, 1'b0, 3, 0);
        run_op(8'h0F, 8'h01, 1'b0, 0, 4);
        run_op(8'h0F, 8'h01, 1'b0, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0, 0);
        run_op(8'h10, 8'h10, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 0, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        check("busy_done_overlap", overlap, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
